// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, looks it up in the direct-mapped
// instruction cache, refills misses one byte at a time from the memory
// controller, and hands (pc, inst) pairs to IF/ID over a valid/ready slot.
module inst_fetch #(
  parameter int unsigned              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              cache_query_o,
  output logic [ADDR_W-1:0] query_addr_o,
  input  logic              inst_hit_i,
  input  logic [31:0]       inst_cache_i,
  output logic              cache_enable_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [31:0]       cache_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_valid_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              out_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_buf;
  logic              r_inst_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_pc_out;

  logic              w_slot_free;
  logic              w_load;
  logic              w_take_byte;
  logic [ADDR_W-1:0] w_branch_pc;
  logic              w_unused_tgt_lsbs;

  // The slot can take a new instruction when it is empty or being drained.
  assign w_slot_free       = !r_inst_valid || out_ready_i;
  assign w_branch_pc       = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign w_unused_tgt_lsbs = ^branch_target_i[1:0];

  // Next-state decode plus the per-state cache/memory strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // through this block leaves one unassigned and a latch is inferred.
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_take_byte    = 1'b0;
    cache_query_o  = 1'b0;
    mem_req_o      = 1'b0;
    cache_enable_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cache_query_o = 1'b1;
        if (inst_hit_i) w_load = w_slot_free;
        else            w_state_next = S_MISS;
      end
      S_MISS: begin
        mem_req_o = 1'b1;
        if (mem_valid_i) begin
          w_take_byte = 1'b1;
          if (r_byte_cnt == 2'd3) w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        cache_enable_o = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // A redirect overrides everything; a FILL write still goes out this cycle.
    if (branch_flag_i) begin
      w_state_next = S_IDLE;
      w_load       = 1'b0;
      w_take_byte  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // PC, refill buffer and output slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_byte_cnt   <= 2'd0;
      r_buf        <= 32'd0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_pc_out     <= '0;
    end else if (branch_flag_i) begin
      r_pc         <= w_branch_pc;
      r_byte_cnt   <= 2'd0;
      r_inst_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_inst       <= inst_cache_i;
        r_pc_out     <= r_pc;
        r_inst_valid <= 1'b1;
        r_pc         <= r_pc + ADDR_W'(4);
      end else if (out_ready_i) begin
        r_inst_valid <= 1'b0;
      end
      if (r_state == S_IDLE && !inst_hit_i) r_byte_cnt <= 2'd0;
      // Byte counter wraps back to 0 after the fourth byte.
      if (w_take_byte) begin
        r_buf[{r_byte_cnt, 3'b000} +: 8] <= mem_rdata_i;
        r_byte_cnt                       <= r_byte_cnt + 2'd1;
      end
    end
  end

  assign query_addr_o = r_pc;
  assign mem_addr_o   = r_pc + ADDR_W'(r_byte_cnt);
  assign cache_addr_o = r_pc;
  assign cache_data_o = r_buf;
  assign inst_valid_o = r_inst_valid;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_out;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with fixed expectations, then a
// randomized run where a cache/memory emulation drives the DUT and a monitor
// compares every accepted (pc, inst) against a queue of expected fetches.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        cache_query_o;
  logic [31:0] query_addr_o;
  logic        inst_hit_i;
  logic [31:0] inst_cache_i;
  logic        cache_enable_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_valid_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        out_ready_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int          n_vec   = 0;
  int          n_err   = 0;
  int          accepts = 0;
  logic        sb_en   = 1'b0;
  exp_t        sb_q[$];
  logic [31:0] cache_mem [logic [31:0]];
  logic [7:0]  fill_bytes [4] = '{8'h13, 8'h05, 8'h10, 8'h00};

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .cache_query_o   (cache_query_o),
    .query_addr_o    (query_addr_o),
    .inst_hit_i      (inst_hit_i),
    .inst_cache_i    (inst_cache_i),
    .cache_enable_o  (cache_enable_o),
    .cache_addr_o    (cache_addr_o),
    .cache_data_o    (cache_data_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rdata_i     (mem_rdata_i),
    .mem_valid_i     (mem_valid_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .out_ready_i     (out_ready_i)
  );

  always #5 clk = ~clk;

  // Backing memory contents: an address hash, read little-endian as words.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[23:16] * 8'd3) ^ a[31:24] ^ 8'hA7;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Instruction pattern used in directed hit scenarios.
  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive_hit();
    inst_hit_i   = 1'b1;
    inst_cache_i = code(query_addr_o);
  endtask

  // Sequential fetch from an aligned start address; earlier expectations die.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      a = start + 32'(4 * i);
      sb_q.push_back('{pc: a, inst: mem_word(a)});
    end
  endtask

  // Scoreboard monitor: looks at each cycle just after the inputs settle.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_en) begin
      if (cache_enable_o) check("fill_data", cache_data_o, mem_word(cache_addr_o));
      if (inst_valid_o && out_ready_i) begin
        accepts++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underrun: got pc_o %h, want an expected entry", pc_o);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", pc_o, e.pc);
          check("sb_inst", inst_o, e.inst);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] t;
    int          wait_cnt;
    int          since;
    int          lim;
    int          r;

    // 1. Reset with random inputs.
    rst = 1'b0;
    repeat (2) begin
      branch_flag_i   = 1'($urandom);
      branch_target_i = $urandom;
      inst_hit_i      = 1'($urandom);
      inst_cache_i    = $urandom;
      mem_rdata_i     = 8'($urandom);
      mem_valid_i     = 1'($urandom);
      out_ready_i     = 1'($urandom);
      @(negedge clk);
    end
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_cache_en", 32'(cache_enable_o), 32'd0);
    rst           = 1'b1;
    branch_flag_i = 1'b0;
    mem_valid_i   = 1'b0;
    out_ready_i   = 1'b1;
    check("rel_query_addr", query_addr_o, 32'd0);
    check("rel_cache_query", 32'(cache_query_o), 32'd1);
    drive_hit();

    // 2. Streaming hits.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(inst_valid_o), 32'd1);
      check("stream_pc", pc_o, 32'(4 * i));
      check("stream_inst", inst_o, code(32'(4 * i)));
      drive_hit();
    end

    // 3. Miss fill at 0x100 (branch there with the slot stalled to test flush).
    @(negedge clk);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h100;
    inst_hit_i      = 1'b0;
    out_ready_i     = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    check("br_flush_valid", 32'(inst_valid_o), 32'd0);
    check("br_query_addr", query_addr_o, 32'h100);
    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("miss_req", 32'(mem_req_o), 32'd1);
        check("miss_addr", mem_addr_o, 32'h100 + 32'(k));
      end
      mem_valid_i = 1'b1;
      mem_rdata_i = fill_bytes[k];
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    check("fill_en", 32'(cache_enable_o), 32'd1);
    check("fill_addr", cache_addr_o, 32'h100);
    check("fill_word", cache_data_o, 32'h0010_0513);
    check("fill_req_low", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    check("requery", 32'(cache_query_o), 32'd1);
    check("requery_addr", query_addr_o, 32'h100);
    check("fill_en_once", 32'(cache_enable_o), 32'd0);
    inst_hit_i   = 1'b1;
    inst_cache_i = 32'h0010_0513;
    out_ready_i  = 1'b1;
    @(negedge clk);
    check("fill_inst", inst_o, 32'h0010_0513);
    check("fill_pc", pc_o, 32'h100);

    // 4. Backpressure for five cycles.
    out_ready_i = 1'b0;
    drive_hit();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(inst_valid_o), 32'd1);
      check("hold_pc", pc_o, 32'h100);
      check("hold_inst", inst_o, 32'h0010_0513);
      check("hold_query", query_addr_o, 32'h104);
      drive_hit();
      if (i == 4) out_ready_i = 1'b1;
    end
    @(negedge clk);
    check("release_pc", pc_o, 32'h104);
    check("release_inst", inst_o, code(32'h104));
    drive_hit();
    @(negedge clk);
    check("release_next_pc", pc_o, 32'h108);

    // 5. Branch in the middle of a miss at 0x200.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h200;
    inst_hit_i      = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    @(negedge clk);
    check("bm_addr0", mem_addr_o, 32'h200);
    mem_valid_i = 1'b1;
    mem_rdata_i = 8'($urandom);
    @(negedge clk);
    mem_valid_i = 1'b0;
    @(negedge clk);
    mem_valid_i = 1'b1;
    @(negedge clk);
    check("bm_req", 32'(mem_req_o), 32'd1);
    check("bm_addr2", mem_addr_o, 32'h202);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h43;
    mem_valid_i     = 1'b1;
    mem_rdata_i     = 8'hEE;
    @(negedge clk);
    branch_flag_i = 1'b0;
    mem_valid_i   = 1'b0;
    check("bm_req_drop", 32'(mem_req_o), 32'd0);
    check("bm_query_addr", query_addr_o, 32'h40);
    check("bm_valid", 32'(inst_valid_o), 32'd0);
    check("bm_no_write", 32'(cache_enable_o), 32'd0);
    check("bm_cache_query", 32'(cache_query_o), 32'd1);
    drive_hit();
    @(negedge clk);
    check("bm_no_write2", 32'(cache_enable_o), 32'd0);
    check("bm_pc_o", pc_o, 32'h40);

    // 6. Wrap-around at the top of the address space.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFE;
    inst_hit_i      = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    check("wrap_align", query_addr_o, 32'hFFFF_FFFC);
    drive_hit();
    @(negedge clk);
    check("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
    check("wrap_query", query_addr_o, 32'h0);

    // Randomized run against the expected fetch stream.
    rst           = 1'b0;
    branch_flag_i = 1'b0;
    inst_hit_i    = 1'b0;
    mem_valid_i   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cache_mem.delete();
    push_stream(32'h0);
    rst      = 1'b1;
    sb_en    = 1'b1;
    wait_cnt = 0;
    since    = 0;
    lim      = int'($urandom_range(3, 40));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cache_enable_o) cache_mem[cache_addr_o] = cache_data_o;
      if (cache_mem.exists(query_addr_o) && $urandom_range(0, 9) != 0) begin
        inst_hit_i   = 1'b1;
        inst_cache_i = cache_mem[query_addr_o];
      end else begin
        inst_hit_i   = 1'b0;
        inst_cache_i = $urandom;
      end
      if (mem_req_o) begin
        if (wait_cnt == 0) begin
          mem_valid_i = 1'b1;
          mem_rdata_i = mem_byte(mem_addr_o);
          wait_cnt    = int'($urandom_range(0, 3));
        end else begin
          mem_valid_i = 1'b0;
          mem_rdata_i = 8'($urandom);
          wait_cnt--;
        end
      end else begin
        mem_valid_i = ($urandom_range(0, 15) == 0);
        mem_rdata_i = 8'($urandom);
      end
      if (since >= lim) begin
        r = int'($urandom_range(0, 3));
        if (r < 2)       t = $urandom_range(0, 255);
        else if (r == 2) t = 32'hFFFF_FFC0 | $urandom_range(0, 63);
        else             t = $urandom;
        branch_flag_i   = 1'b1;
        branch_target_i = t;
        out_ready_i     = 1'b0;
        push_stream({t[31:2], 2'b00});
        since = 0;
        lim   = int'($urandom_range(3, 40));
      end else begin
        branch_flag_i   = 1'b0;
        branch_target_i = $urandom;
        out_ready_i     = ($urandom_range(0, 3) != 0);
        since++;
      end
      @(negedge clk);
    end
    sb_en = 1'b0;
    check("progress", 32'(accepts >= 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the direct-mapped instruction cache.
- Holds the PC and looks up each PC in the cache (combinational lookup, same-cycle hit).
- On a miss, fetches the 32-bit instruction byte-by-byte from the memory controller, writes the word into the cache, then re-queries.
- Delivers (pc, inst) pairs to IF/ID over a valid/ready handshake, and redirects on branch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
ADDR_W, 32, width of the PC and all address ports.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
branch_flag_i  in  1  redirect request from EX.
branch_target_i  in  ADDR_W  redirect target; bits [1:0] forced to 0.
cache_query_o  out  1  cache lookup enable.
query_addr_o  out  ADDR_W  lookup address (= pc).
inst_hit_i  in  1  cache hit, valid in the same cycle as the query.
inst_cache_i  in  32  cached word on hit.
cache_enable_o  out  1  one-cycle cache write strobe.
cache_addr_o  out  ADDR_W  write address.
cache_data_o  out  32  write data.
mem_req_o  out  1  byte-read request to the memory controller.
mem_addr_o  out  ADDR_W  byte address being requested.
mem_rdata_i  in  8  returned byte.
mem_valid_i  in  1  mem_rdata_i valid; one pulse per requested byte.
inst_valid_o  out  1  output slot holds a valid instruction.
inst_o  out  32  instruction.
pc_o  out  ADDR_W  address of inst_o.
out_ready_i  in  1  IF/ID accepts the slot this cycle.

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC, state=IDLE, byte_cnt=0, buffer=0.
  - All outputs 0 (inst_valid_o=0, inst_o=0, pc_o=0, mem_req_o=0, cache_enable_o=0).
  - Reset mid-miss aborts the miss; no cache write results.
- slot_free = !inst_valid_o || out_ready_i.
- Output hold: while inst_valid_o && !out_ready_i, inst_o and pc_o stay stable.
- Output drain: on accept with no new load, inst_valid_o falls next cycle.
- IDLE:
  - cache_query_o=1, query_addr_o=pc.
  - Hit && slot_free: next cycle inst_o=inst_cache_i, pc_o=pc, inst_valid_o=1, pc=pc+4. Sustains 1 inst/cycle on hits.
  - Hit && !slot_free: stay in IDLE, pc unchanged.
  - Miss: go to MISS with byte_cnt=0. Does not wait for slot_free.
- MISS:
  - cache_query_o=0, mem_req_o=1, mem_addr_o=pc+byte_cnt, held stable until mem_valid_i.
  - On mem_valid_i: buffer[8*byte_cnt +: 8]=mem_rdata_i (little-endian), byte_cnt++.
  - On the 4th byte: go to FILL. mem_req_o is 0 in the following cycle.
- FILL (exactly 1 cycle):
  - cache_enable_o=1, cache_addr_o=pc, cache_data_o=buffer.
  - Then return to IDLE, which re-queries and hits.
  - Miss penalty = 4 byte latencies + 2 cycles.
- Branch (branch_flag_i==1), highest priority in every state:
  - Next cycle: pc={branch_target_i[ADDR_W-1:2],2'b00}, inst_valid_o=0 (slot flushed regardless of out_ready_i), state=IDLE, byte_cnt=0.
  - In MISS: mem_req_o drops next cycle. A mem_valid_i in the same cycle is ignored; no cache write.
  - In FILL: the cache write still occurs (data is correct for its address); PC is redirected.
- mem_valid_i outside MISS is ignored.
- Wrap-around: pc+4 and pc+byte_cnt wrap modulo 2^ADDR_W; 0xFFFFFFFC advances to 0x00000000.
- pc always word-aligned.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0. After release, query_addr_o=0x0, cache_query_o=1.
2. Streaming hits: inst_hit_i=1 constant, inst_cache_i=pc-dependent, out_ready_i=1 -> pc_o=0,4,8,C on consecutive cycles, inst_valid_o=1 continuously.
3. Miss fill:
   - Stimulus: miss at pc=0x100; bytes 0x13,0x05,0x10,0x00 returned with 3-cycle gaps.
   - Response: mem_addr_o=0x100..0x103 in order, then one cycle cache_enable_o=1 with cache_addr_o=0x100 and cache_data_o=0x00100513.
   - Next IDLE query hits and outputs inst_o=0x00100513, pc_o=0x100.
4. Backpressure: out_ready_i=0 for 5 cycles with hits -> inst_o/pc_o frozen, pc not advanced. Release -> next pc delivered the following cycle, no skip or duplicate.
5. Branch mid-miss:
   - Stimulus: after 2 bytes of a miss at 0x200, branch_flag_i=1 with target 0x40 coincident with mem_valid_i.
   - Response: mem_req_o=0 and pc=0x40 next cycle, no cache_enable_o, inst_valid_o=0, query_addr_o=0x40.
6. Wrap: branch to 0xFFFFFFFE -> pc=0xFFFFFFFC; a hit there -> next query_addr_o=0x00000000.
